// File: rtl/rv32_pkg.sv
// Shared types and default widths for the RV32 memory arbiter.
package rv32_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rv32_mem_arb.sv
// Fetch/load-store arbiter onto one shared memory port, with fetch anti-starvation.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module rv32_mem_arb
    import rv32_pkg::*;
#(
    parameter int ADDR_W     = rv32_pkg::ADDR_W,
    parameter int DATA_W     = rv32_pkg::DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int STV_W  = $clog2(STARVE_MAX + 1);

    arb_state_t         state;
    logic [STV_W-1:0]   starve_cnt;
    logic               fetch_wins;
    logic               grant_i;
    logic               grant_d;
    logic               wd_expire;

    // Grants are combinational so the requester sees them in the cycle it asks.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        fetch_wins = 1'b0;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        if (!rst && state == IDLE) begin
            fetch_wins = i_req && (!d_req || starve_cnt == STV_W'(STARVE_MAX));
            grant_i    = fetch_wins;
            grant_d    = d_req && !fetch_wins;
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] wd_cnt;

    // The grant cycle counts as cycle one, so the error response lands TIMEOUT cycles after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (grant_i || grant_d) begin
            wd_cnt <= TMO_W'(1);
        end else if (state != IDLE && !wd_expire) begin
            wd_cnt <= wd_cnt + TMO_W'(1);
        end
    end

    assign wd_expire = (state != IDLE) && (wd_cnt == TMO_W'(TIMEOUT - 1));
`else
    // No watchdog: a BUSY state waits for mem_ack however long it takes.
    assign wd_expire = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= i_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                        starve_cnt <= '0;
                    end else if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : STRB_W'(0);
                        // Only data grants that made fetch wait count towards starvation.
                        if (!i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + STV_W'(1);
                        end
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_rdata;
                        end
                    end else if (wd_expire) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rvalid <= 1'b1;
                            i_err    <= 1'b1;
                            i_rdata  <= '0;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= '0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arb.sv
// Scoreboard bench for rv32_mem_arb: directed stimulus pushes expectations, monitors pop and compare.
// Define MEM_ARB_TIMEOUT_EN to exercise the watchdog scenario instead of the indefinite-wait one.
module tb_rv32_mem_arb;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
    } mem_txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_gnt_cyc = -10;
    bit resp_en = 1'b1;

    mem_txn_t mem_q[$];
    bit       gnt_q[$];   // 0 = fetch, 1 = data
    rsp_t     irsp_q[$];
    rsp_t     drsp_q[$];

    rv32_mem_arb #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
    endtask

    // Grant monitor: order, exclusivity, spacing, never while the port is busy.
    always @(negedge clk) begin
        if (i_gnt || d_gnt) begin
            check("gnt_one_hot", {i_gnt, d_gnt} == 2'b11, 1'b0);
            check("gnt_while_busy", mem_req, 1'b0);
            check("gnt_spacing", (cyc - last_gnt_cyc) >= 2, 1'b1);
            last_gnt_cyc = cyc;
            if (gnt_q.size() == 0) fail_now("gnt_unexpected");
            else check("gnt_port", d_gnt, gnt_q.pop_front());
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (i_rvalid) begin
            if (irsp_q.size() == 0) fail_now("i_rvalid_unexpected");
            else begin
                e = irsp_q.pop_front();
                check("i_rdata", i_rdata, e.rdata);
                check("i_err", i_err, e.err);
            end
        end else if (i_err) fail_now("i_err_without_rvalid");
        if (d_rvalid) begin
            if (drsp_q.size() == 0) fail_now("d_rvalid_unexpected");
            else begin
                e = drsp_q.pop_front();
                check("d_rdata", d_rdata, e.rdata);
                check("d_err", d_err, e.err);
            end
        end else if (d_err) fail_now("d_err_without_rvalid");
    end

    // Memory responder: checks the request fields, holds them stable, then acks.
    initial begin
        mem_txn_t t;
        logic [69:0] snap;
        forever begin
            @(negedge clk);
            if (resp_en && mem_req) begin
                if (mem_q.size() == 0) begin
                    fail_now("mem_req_unexpected");
                    t = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0, delay: 1};
                end else begin
                    t = mem_q.pop_front();
                    check("mem_we", mem_we, t.we);
                    check("mem_addr", mem_addr, t.addr);
                    check("mem_wstrb", mem_wstrb, t.wstrb);
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                end
                snap = {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
                for (int k = 1; k < t.delay; k++) begin
                    @(negedge clk);
                    check("mem_stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}, snap);
                end
                @(posedge clk); #1;
                mem_ack   = 1'b1;
                mem_rdata = t.rdata;
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0BAD_0BAD;
            end
        end
    end

    task automatic drive_i(input logic [31:0] addr, input bit keep);
        int n = 0;
        i_addr = addr;
        i_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!i_gnt && n < 300);
        if (!i_gnt) fail_now("i_gnt_timeout");
        @(posedge clk); #1;
        if (!keep) i_req = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit keep);
        int n = 0;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_wstrb = wstrb;
        d_req   = 1'b1;
        do begin @(negedge clk); n++; end while (!d_gnt && n < 300);
        if (!d_gnt) fail_now("d_gnt_timeout");
        @(posedge clk); #1;
        if (!keep) d_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mem_q.size() != 0 || gnt_q.size() != 0 || irsp_q.size() != 0 ||
                drsp_q.size() != 0 || mem_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state, with both requests pending: nothing may be granted.
        #2;
        check("rst_i_gnt", i_gnt, 1'b0);
        check("rst_d_gnt", d_gnt, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        check("rst_err", {i_err, d_err}, 2'b00);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 69'h0);
        #15;
        i_req = 1'b0;
        d_req = 1'b0;
        #4;
        rst = 1'b0;

        // Fetch only, ack 3 cycles after mem_req.
        gnt_q.push_back(1'b0);
        mem_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0000_0013, delay: 3});
        irsp_q.push_back('{rdata: 32'h0000_0013, err: 1'b0});
        @(posedge clk); #1;
        drive_i(32'h100, 1'b0);
        drain();

        // Conflict: data write wins, fetch follows.
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        mem_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, rdata: 32'h0000_0001, delay: 2});
        mem_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0000_0093, delay: 1});
        drsp_q.push_back('{rdata: 32'h0000_0001, err: 1'b0});
        irsp_q.push_back('{rdata: 32'h0000_0093, err: 1'b0});
        @(posedge clk); #1;
        fork
            drive_i(32'h104, 1'b0);
            drive_d(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0);
        join
        drain();

        // Starvation: four data reads, one fetch, then data resumes. Reads drive strobe 0.
        for (int k = 0; k < 4; k++) gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        for (int k = 0; k < 4; k++) begin
            mem_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * k), wdata: 32'h0, wstrb: 4'h0,
                              rdata: 32'h1111_0000 + 32'(k), delay: 1});
            drsp_q.push_back('{rdata: 32'h1111_0000 + 32'(k), err: 1'b0});
        end
        mem_q.push_back('{we: 1'b0, addr: 32'h120, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0000_0033, delay: 1});
        irsp_q.push_back('{rdata: 32'h0000_0033, err: 1'b0});
        mem_q.push_back('{we: 1'b0, addr: 32'h310, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h2222_0005, delay: 1});
        drsp_q.push_back('{rdata: 32'h2222_0005, err: 1'b0});
        @(posedge clk); #1;
        fork
            drive_i(32'h120, 1'b0);
            begin
                for (int k = 0; k < 4; k++) drive_d(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF, 1'b1);
                drive_d(1'b0, 32'h310, 32'h0, 4'hF, 1'b0);
            end
        join
        drain();

        // Byte write with strobe 0x2, then a fetch that must drive strobe 0.
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        mem_q.push_back('{we: 1'b1, addr: 32'h404, wdata: 32'h0000_AB00, wstrb: 4'h2, rdata: 32'h0000_0000, delay: 3});
        mem_q.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0000_0073, delay: 2});
        drsp_q.push_back('{rdata: 32'h0000_0000, err: 1'b0});
        irsp_q.push_back('{rdata: 32'h0000_0073, err: 1'b0});
        @(posedge clk); #1;
        drive_d(1'b1, 32'h404, 32'h0000_AB00, 4'h2, 1'b0);
        drive_i(32'h108, 1'b0);
        drain();

        // Reset mid-transfer, ack arrives after reset and must be ignored.
        resp_en = 1'b0;
        gnt_q.push_back(1'b1);
        @(posedge clk); #1;
        drive_d(1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
        check("busy_mem_req", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mem_req", mem_req, 1'b0);
        check("async_rst_outputs", {d_gnt, d_rvalid, d_err}, 3'b000);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("late_ack_mem_req", mem_req, 1'b0);
        check("late_ack_d_rdata", d_rdata, 32'h0);
        drain();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: no ack, error response 8 cycles after the grant.
        gnt_q.push_back(1'b1);
        drsp_q.push_back('{rdata: 32'h0, err: 1'b1});
        @(posedge clk); #1;
        drive_d(1'b0, 32'h600, 32'h0, 4'h0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!d_rvalid) check("tmo_mem_req_held", mem_req, 1'b1);
        end while (!d_rvalid && n < 40);
        check("tmo_latency", n, 8);
        check("tmo_mem_req_dropped", mem_req, 1'b0);
        drain();
`else
        // No watchdog: BUSY waits well past any timeout, then completes normally.
        gnt_q.push_back(1'b1);
        drsp_q.push_back('{rdata: 32'h0000_00AA, err: 1'b0});
        @(posedge clk); #1;
        drive_d(1'b0, 32'h600, 32'h0, 4'h0, 1'b0);
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        check("no_wd_mem_req_held", n, 80);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_00AA;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        drain();
`endif
        resp_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_mem_arb.md
RV32_MEM_ARB -- requirements
Module: rv32_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive data grants while fetch waits.
REQ-004 SHALL have parameter TIMEOUT, default 64, the watchdog limit in cycles (used only with the macro).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have ports i_req in 1, i_addr in ADDR_W, i_gnt out 1, i_rvalid out 1, i_rdata out DATA_W, i_err out 1: the read-only fetch requester.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_wstrb in DATA_W/8, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W, d_err out 1: the load/store requester.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_wstrb out DATA_W/8, mem_ack in 1, mem_rdata in DATA_W: the single shared memory port.

Function
REQ-010 SHALL implement the states IDLE, BUSY_I and BUSY_D.
REQ-011 In IDLE with any request pending, SHALL grant one requester: i_gnt/d_gnt is a one-cycle combinational pulse, the request fields are latched, and the next state is BUSY_I or BUSY_D.
REQ-012 SHALL give data priority over fetch, unless starve_cnt==STARVE_MAX and i_req is high, in which case fetch SHALL win.
REQ-013 starve_cnt SHALL increment on each data grant while i_req is high, saturate at STARVE_MAX, and clear on a fetch grant or on a data grant with i_req low.
REQ-014 In BUSY_*, mem_req SHALL be high, registered, from the cycle after the grant, with the mem_* fields stable until mem_ack.
REQ-015 On mem_ack in BUSY_x, SHALL register mem_rdata into x_rdata, pulse x_rvalid for one cycle in the next cycle, deassert mem_req in that same next cycle, and return to IDLE.
REQ-016 Grant-to-grant spacing SHALL be at least 2 cycles; no grant is issued in a BUSY state.
REQ-017 mem_ack SHALL be ignored in IDLE.
REQ-018 A fetch SHALL always drive mem_we=0 and mem_wstrb=0; a data write SHALL pass d_wstrb through, and a data read SHALL drive strobe 0.
REQ-019 x_rdata SHALL hold its last value between responses; x_err SHALL be 0 except as stated in REQ-024.
REQ-020 Simultaneous i_req and d_req in IDLE SHALL be resolved per REQ-012 in that cycle; the loser holds its request and is not dropped.

Reset
REQ-021 Asserting rst SHALL immediately force IDLE, starve_cnt=0, mem_req=0, every gnt/rvalid/err output=0, and every rdata/latched field=0.
REQ-022 Reset during BUSY SHALL abandon the transfer with no rvalid; a late mem_ack is ignored per REQ-017.

Configuration
REQ-023 Macro MEM_ARB_TIMEOUT_EN SHALL control the watchdog; without it there is no watchdog and BUSY waits indefinitely for mem_ack.
REQ-024 With the macro, a cycle counter SHALL clear on grant and count while in BUSY; at TIMEOUT cycles without mem_ack, the block SHALL drop mem_req, pulse x_rvalid with x_err=1 and x_rdata=0, and return to IDLE.

Structure
REQ-025 The package rv32_pkg SHALL hold the state enum arb_state_t (IDLE, BUSY_I, BUSY_D) and the default widths ADDR_W and DATA_W.
REQ-026 The block SHALL be a single module with no sub-module; the starvation counter and the watchdog are inline.

Verification
REQ-027 Fetch only: i_req with i_addr=0x100, mem_ack 3 cycles after mem_req, mem_rdata=0x00000013 -> i_gnt pulses once, mem_addr=0x100, mem_we=0, i_rvalid follows with i_rdata=0x00000013.
REQ-028 Conflict: i_req and d_req in the same cycle, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF -> data is granted first and the memory sees that write; fetch is granted 2 cycles after the data mem_ack at the earliest.
REQ-029 Starvation: d_req held high continuously with i_req high and STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-030 Reset mid-transfer: rst pulsed 11 time units during BUSY_D, with mem_ack arriving after reset -> mem_req falls asynchronously, and there is no d_rvalid and no grant until a new request.
REQ-031 Timeout (macro defined, TIMEOUT=8): mem_ack never arrives -> 8 cycles after the grant, d_rvalid=1, d_err=1, mem_req=0, and the state returns to IDLE.
REQ-032 Byte write: d_we=1, d_wstrb=0x2 -> mem_wstrb=0x2 throughout BUSY_D; a following fetch drives mem_wstrb=0.
